// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the multicycle instruction fetch stage:
// FSM state encoding, reset/step defaults and the word-alignment mask.
package cpu_fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_STEP  = 4;

    // Clears the two byte-offset bits; callers slice it to their address width.
    localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with aligned redirect load, post-commit increment and a
// latch that holds a redirect target arriving while a fetch is in flight.
module fetch_pc_reg
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned             PC_STEP    = DEFAULT_PC_STEP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] redirect,
    input  logic                  load_en,
    input  logic                  load_from_latch,
    input  logic                  inc_en,
    input  logic                  latch_en,
    output logic [ADDR_WIDTH-1:0] redirect_aligned,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = WORD_ALIGN_MASK[ADDR_WIDTH-1:0];

    logic [ADDR_WIDTH-1:0] target_q;

    assign redirect_aligned = redirect & ALIGN_MASK;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            target_q <= RESET_PC;
        end else begin
            if (load_en) begin
                pc <= load_from_latch ? target_q : redirect_aligned;
            end else if (inc_en) begin
                pc <= pc + ADDR_WIDTH'(PC_STEP);
            end
            if (latch_en) begin
                target_q <= redirect_aligned;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: issues one instruction-memory read per request,
// strobes the fetched word into the instruction register, handles redirects.
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned             PC_STEP    = DEFAULT_PC_STEP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  FetchStart,
    input  logic                  PCWrite,
    input  logic [ADDR_WIDTH-1:0] PCNext,
    output logic                  MemReq,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    input  logic [DATA_WIDTH-1:0] MemRdata,
    input  logic                  MemReady,
    output logic [DATA_WIDTH-1:0] InstructionOut,
    output logic                  IRWrite,
    output logic [ADDR_WIDTH-1:0] PCOut,
    output logic                  Busy,
    output logic [31:0]           FetchCount
);

    fetch_state_e          state_q, state_d;
    logic                  squash_q;
    logic                  launch, commit, squash_done;
    logic [ADDR_WIDTH-1:0] redirect_aligned;
    logic [ADDR_WIDTH-1:0] pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        commit      = 1'b0;
        squash_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (FetchStart) begin
                    launch  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (MemReady) begin
                    state_d = IDLE;
                    // A redirect arriving with the data still kills the word.
                    if (squash_q || PCWrite) begin
                        squash_done = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    fetch_pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC),
        .PC_STEP    (PC_STEP)
    ) u_pc (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect         (PCNext),
        .load_en          ((state_q == IDLE && PCWrite) || squash_done),
        .load_from_latch  (squash_done && !PCWrite),
        .inc_en           (commit),
        .latch_en         (state_q == WAIT && PCWrite),
        .redirect_aligned (redirect_aligned),
        .pc               (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash_q       <= 1'b0;
            MemAddr        <= RESET_PC;
            InstructionOut <= '0;
            IRWrite        <= 1'b0;
            FetchCount     <= '0;
        end else begin
            if (state_q == WAIT) begin
                if (MemReady) begin
                    squash_q <= 1'b0;
                end else if (PCWrite) begin
                    squash_q <= 1'b1;
                end
            end else begin
                squash_q <= 1'b0;
            end

            if (launch) begin
                MemAddr <= PCWrite ? redirect_aligned : pc;
            end

            if (commit) begin
                InstructionOut <= MemRdata;
                FetchCount     <= FetchCount + 32'd1;
            end
            IRWrite <= commit;
        end
    end

    // The state register doubles as the request/busy flop.
    assign MemReq = (state_q == WAIT);
    assign Busy   = (state_q == WAIT);
    assign PCOut  = pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected
// instruction-register writes checked whenever IRWrite is seen.
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        FetchStart;
    logic        PCWrite;
    logic [31:0] PCNext;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic [31:0] MemRdata;
    logic        MemReady;
    logic [31:0] InstructionOut;
    logic        IRWrite;
    logic [31:0] PCOut;
    logic        Busy;
    logic [31:0] FetchCount;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic prev_ir     = 1'b0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .FetchStart     (FetchStart),
        .PCWrite        (PCWrite),
        .PCNext         (PCNext),
        .MemReq         (MemReq),
        .MemAddr        (MemAddr),
        .MemRdata       (MemRdata),
        .MemReady       (MemReady),
        .InstructionOut (InstructionOut),
        .IRWrite        (IRWrite),
        .PCOut          (PCOut),
        .Busy           (Busy),
        .FetchCount     (FetchCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        sb.push_back(e);
    endtask

    // Scoreboard side: every IRWrite pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && IRWrite === 1'b1) begin
            check("ir_not_back_to_back", {63'd0, prev_ir}, 64'd0);
            if (sb.size() == 0) begin
                check("ir_unexpected_pulse", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_instruction", {32'd0, InstructionOut}, {32'd0, e.instr});
                check("sb_pc_after_commit", {32'd0, PCOut}, {32'd0, e.pc});
            end
        end
        prev_ir = IRWrite;
    end

    initial begin
        rst_n      = 1'b0;
        FetchStart = 1'b0;
        PCWrite    = 1'b0;
        PCNext     = '0;
        MemRdata   = '0;
        MemReady   = 1'b0;
        repeat (3) step();

        check("rst_memreq", {63'd0, MemReq}, 64'd0);
        check("rst_memaddr", {32'd0, MemAddr}, 64'd0);
        check("rst_instr", {32'd0, InstructionOut}, 64'd0);
        check("rst_irwrite", {63'd0, IRWrite}, 64'd0);
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_count", {32'd0, FetchCount}, 64'd0);
        check("rst_pc", {32'd0, PCOut}, 64'd0);
        rst_n = 1'b1;
        step();

        // Minimum-latency fetch.
        FetchStart = 1'b1;
        step();
        FetchStart = 1'b0;
        check("t1_memreq", {63'd0, MemReq}, 64'd1);
        check("t1_memaddr", {32'd0, MemAddr}, 64'h0);
        check("t1_busy", {63'd0, Busy}, 64'd1);
        MemReady = 1'b1;
        MemRdata = 32'h8C22_0004;
        push_exp(32'h8C22_0004, 32'h4);
        step();
        MemReady = 1'b0;
        check("t1_irwrite", {63'd0, IRWrite}, 64'd1);
        check("t1_pc", {32'd0, PCOut}, 64'h4);
        check("t1_count", {32'd0, FetchCount}, 64'd1);
        check("t1_memreq_drop", {63'd0, MemReq}, 64'd0);
        step();
        check("t1_ir_one_cycle", {63'd0, IRWrite}, 64'd0);

        // MemReady delayed to cycle 5; FetchStart toggled while waiting.
        FetchStart = 1'b1;
        step();
        for (int i = 1; i <= 5; i++) begin
            check("t2_memreq_held", {63'd0, MemReq}, 64'd1);
            check("t2_memaddr_held", {32'd0, MemAddr}, 64'h4);
            check("t2_busy", {63'd0, Busy}, 64'd1);
            check("t2_no_early_ir", {63'd0, IRWrite}, 64'd0);
            FetchStart = i[0];
            if (i == 5) begin
                FetchStart = 1'b0;
                MemReady   = 1'b1;
                MemRdata   = 32'h2402_0001;
                push_exp(32'h2402_0001, 32'h8);
            end
            step();
        end
        MemReady = 1'b0;
        check("t2_irwrite", {63'd0, IRWrite}, 64'd1);
        check("t2_count", {32'd0, FetchCount}, 64'd2);
        step();
        check("t2_ir_one_cycle", {63'd0, IRWrite}, 64'd0);
        check("t2_idle", {63'd0, MemReq}, 64'd0);

        // Redirect and FetchStart together in IDLE: target wins, low bits cleared.
        PCWrite    = 1'b1;
        PCNext     = 32'h0000_0043;
        FetchStart = 1'b1;
        step();
        PCWrite    = 1'b0;
        FetchStart = 1'b0;
        check("t3_memaddr", {32'd0, MemAddr}, 64'h40);
        check("t3_pc", {32'd0, PCOut}, 64'h40);
        MemReady = 1'b1;
        MemRdata = 32'h1234_5678;
        push_exp(32'h1234_5678, 32'h44);
        step();
        MemReady = 1'b0;
        check("t3_pc_after", {32'd0, PCOut}, 64'h44);
        check("t3_count", {32'd0, FetchCount}, 64'd3);
        step();

        // Redirect during WAIT squashes the in-flight fetch.
        FetchStart = 1'b1;
        step();
        FetchStart = 1'b0;
        check("t4_memaddr", {32'd0, MemAddr}, 64'h44);
        PCWrite = 1'b1;
        PCNext  = 32'h0000_0100;
        step();
        PCWrite = 1'b0;
        check("t4_memreq_held", {63'd0, MemReq}, 64'd1);
        check("t4_memaddr_held", {32'd0, MemAddr}, 64'h44);
        step();
        MemReady = 1'b1;
        MemRdata = 32'hDEAD_BEEF;
        step();
        MemReady = 1'b0;
        check("t4_no_irwrite", {63'd0, IRWrite}, 64'd0);
        check("t4_instr_kept", {32'd0, InstructionOut}, 64'h1234_5678);
        check("t4_pc_target", {32'd0, PCOut}, 64'h100);
        check("t4_count_same", {32'd0, FetchCount}, 64'd3);
        check("t4_idle", {63'd0, Busy}, 64'd0);
        FetchStart = 1'b1;
        step();
        FetchStart = 1'b0;
        check("t4_refetch_addr", {32'd0, MemAddr}, 64'h100);
        MemReady = 1'b1;
        MemRdata = 32'hA5A5_A5A5;
        push_exp(32'hA5A5_A5A5, 32'h104);
        step();
        MemReady = 1'b0;
        check("t4_refetch_count", {32'd0, FetchCount}, 64'd4);
        step();

        // Redirect in the same cycle as MemReady also squashes.
        FetchStart = 1'b1;
        step();
        FetchStart = 1'b0;
        check("t4b_memaddr", {32'd0, MemAddr}, 64'h104);
        MemReady = 1'b1;
        MemRdata = 32'h0BAD_0BAD;
        PCWrite  = 1'b1;
        PCNext   = 32'h0000_0203;
        step();
        MemReady = 1'b0;
        PCWrite  = 1'b0;
        check("t4b_no_irwrite", {63'd0, IRWrite}, 64'd0);
        check("t4b_pc", {32'd0, PCOut}, 64'h200);
        check("t4b_count", {32'd0, FetchCount}, 64'd4);
        check("t4b_instr_kept", {32'd0, InstructionOut}, 64'hA5A5_A5A5);
        step();

        // Reset asserted mid-fetch; a late MemReady must be ignored.
        FetchStart = 1'b1;
        step();
        FetchStart = 1'b0;
        check("t5_memreq_before", {63'd0, MemReq}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_memreq_async", {63'd0, MemReq}, 64'd0);
        check("t5_pc_reset", {32'd0, PCOut}, 64'h0);
        step();
        rst_n    = 1'b1;
        MemReady = 1'b1;
        MemRdata = 32'hFFFF_0000;
        step();
        MemReady = 1'b0;
        check("t5_no_irwrite", {63'd0, IRWrite}, 64'd0);
        check("t5_stay_idle", {63'd0, Busy}, 64'd0);
        check("t5_count", {32'd0, FetchCount}, 64'd0);
        check("t5_pc", {32'd0, PCOut}, 64'h0);
        step();

        // PC wraps to zero after committing from the top word.
        PCWrite = 1'b1;
        PCNext  = 32'hFFFF_FFFF;
        step();
        PCWrite = 1'b0;
        check("t6_pc_preset", {32'd0, PCOut}, 64'hFFFF_FFFC);
        FetchStart = 1'b1;
        step();
        FetchStart = 1'b0;
        check("t6_memaddr", {32'd0, MemAddr}, 64'hFFFF_FFFC);
        MemReady = 1'b1;
        MemRdata = 32'hCAFE_F00D;
        push_exp(32'hCAFE_F00D, 32'h0);
        step();
        MemReady = 1'b0;
        check("t6_pc_wrap", {32'd0, PCOut}, 64'h0);
        check("t6_count", {32'd0, FetchCount}, 64'd1);

        repeat (3) step();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Multicycle fetch stage that sits directly upstream of the instruction register and feeds its InstructionIn/IRWrite pair.
- Owns the PC and issues one instruction-memory read per fetch request over a ready-based handshake with variable latency.
- On completion, presents the fetched word with a one-cycle IRWrite strobe, then advances PC.
- Accepts PC redirects (branch/jump) from the control path, including squash of an in-flight fetch.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, PC / memory address width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, PC increment per committed fetch

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
FetchStart  input  1  control FSM requests one fetch; honoured only in IDLE
PCWrite  input  1  load PC from PCNext (redirect)
PCNext  input  ADDR_WIDTH  redirect target; bits [1:0] ignored (forced 00)
MemReq  output  1  read request to instruction memory, held until MemReady
MemAddr  output  ADDR_WIDTH  read address, stable while MemReq=1
MemRdata  input  DATA_WIDTH  memory read data, valid when MemReady=1
MemReady  input  1  memory completes the read this cycle
InstructionOut  output  DATA_WIDTH  fetched word; drives instruction register InstructionIn
IRWrite  output  1  one-cycle strobe; instruction register captures InstructionOut
PCOut  output  ADDR_WIDTH  current PC
Busy  output  1  high while a fetch is outstanding
FetchCount  output  32  committed (non-squashed) fetches, wraps at 2^32

Behaviour:
- Reset (async, rst_n=0): state=IDLE; PC=RESET_PC; MemReq=0; MemAddr=RESET_PC; InstructionOut=0; IRWrite=0; Busy=0; FetchCount=0; squash flag=0.
  - Reset mid-fetch drops MemReq immediately; the late MemReady from memory is ignored because state is IDLE.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - IDLE
  - WAIT
- IDLE:
  - PCWrite=1 alone: PC <= {PCNext[ADDR_WIDTH-1:2],2'b00}.
  - FetchStart=1: next cycle state=WAIT, MemReq=1, Busy=1, MemAddr=PC.
  - FetchStart and PCWrite in the same cycle: PC loads the target, and MemAddr = the target (redirect wins).
- WAIT:
  - MemReq and MemAddr are held stable; FetchStart is ignored.
  - MemReady=0: remain in WAIT with no limit (no timeout).
  - MemReady=1, squash=0: next cycle InstructionOut <= MemRdata, IRWrite=1 for exactly one cycle, PC <= PC+PC_STEP (mod 2^ADDR_WIDTH), FetchCount+1, MemReq=0, Busy=0, state=IDLE.
  - MemReady=1, squash=1: next cycle InstructionOut unchanged, IRWrite=0, PC <= latched redirect target, FetchCount unchanged, squash cleared, state=IDLE.
  - PCWrite=1: set squash and latch the target; a later PCWrite overwrites the latched target.
  - PCWrite in the same cycle as MemReady: counts as a squash, so the in-flight word is discarded and the new target is loaded.
- Latency:
  - FetchStart sampled at cycle 0 gives MemReq at cycle 1.
  - MemReady sampled at cycle k≥1 gives IRWrite at cycle k+1.
  - Minimum is 2 cycles from request to IRWrite.
- IRWrite is never high in two consecutive cycles.
- IRWrite is high only in the cycle after a WAIT→IDLE transition that was not squashed.
- PC wrap: PC = 2^ADDR_WIDTH - PC_STEP followed by a commit gives PC = 0.

Decomposition:
- Shared package cpu_fetch_pkg:
  - fetch state encoding (IDLE=0, WAIT=1)
  - RESET_PC and PC_STEP defaults
  - word-alignment mask constant
- One natural sub-module: fetch_pc_reg.
  - Contents: PC register with async reset, increment, aligned load, and the squash-target latch.
  - The top level holds the FSM, memory handshake, output registers and counter.

Test Plan:
- Reset then FetchStart at cycle 0, MemReady=1 at cycle 1 with MemRdata=0x8C220004 → MemAddr=0x0 at cycle 1; IRWrite=1 and InstructionOut=0x8C220004 at cycle 2; PCOut=0x4; FetchCount=1.
- FetchStart with MemReady delayed 5 cycles → MemReq and MemAddr stable for cycles 1–5; Busy=1; IRWrite pulses once at cycle 6 only; FetchStart pulses during WAIT are ignored.
- PCWrite=1, PCNext=0x00000043 with FetchStart in IDLE → MemAddr=0x40; after commit PCOut=0x44.
- PCWrite=1, PCNext=0x100 during WAIT, then MemReady=1 → no IRWrite; InstructionOut keeps its old value; PCOut=0x100; FetchCount unchanged; the next fetch reads 0x100.
- rst_n low during WAIT, with MemReady=1 one cycle after release → MemReq=0 immediately; PCOut=RESET_PC; no IRWrite; state stays IDLE.
- PC preset to 0xFFFFFFFC via PCWrite, then one fetch committed → PCOut=0x00000000.
